voice_allocator: RTL

Polyphonic voice scheduler between the keyboard event decoder and the `Synthesizer` voice bank. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` synth voices. Assignment prefers a retrigger of the same note, then a free voice, then steals the least-recently-allocated voice. It drives the per-voice `frequencies` and `voice_volumes` arrays consumed by `Synthesizer`, including a linear release ramp after note-off.

---
 rtl/voice_pkg.sv | 20 ++
 rtl/voice_env.sv | 25 ++
 rtl/voice_allocator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared types and default sizing for the polyphonic voice allocator.
package voice_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam int NUM_VOICES = 8;
  localparam int NOTE_W     = 7;
  localparam int FREQ_W     = 32;
  localparam int VOL_W      = 32;
  localparam int AGE_W      = $clog2(NUM_VOICES);

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              held;
    logic [AGE_W-1:0]  age;
    logic [FREQ_W-1:0] freq;
    logic [VOL_W-1:0]  vol;
  } voice_t;

endpackage

// File: rtl/voice_env.sv
// Per-voice volume envelope: full-scale load on note-on, saturating linear
// release on each envelope tick once the key is up.
module voice_env #(
  parameter int               VOL_W    = voice_pkg::VOL_W,
  parameter logic [VOL_W-1:0] VOL_MAX  = VOL_W'(32'h0000_FFFF),
  parameter logic [VOL_W-1:0] REL_STEP = VOL_W'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             held,
  input  logic             tick,
  output logic [VOL_W-1:0] vol
);

  always_ff @(posedge clk) begin
    if (reset)
      vol <= '0;
    else if (load)
      vol <= VOL_MAX;
    else if (tick && !held && vol != '0)
      vol <= (vol > REL_STEP) ? vol - REL_STEP : '0;
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice scheduler: retrigger > lowest free voice > steal LRU, one voice
// examined per SCAN cycle, chosen voice updated in COMMIT.
module voice_allocator #(
  parameter int               NUM_VOICES = 8,
  parameter int               NOTE_W     = 7,
  parameter int               FREQ_W     = 32,
  parameter int               VOL_W      = 32,
  parameter logic [VOL_W-1:0] VOL_MAX    = VOL_W'(32'h0000_FFFF),
  parameter logic [VOL_W-1:0] REL_STEP   = VOL_W'(32'h0000_0100),
  parameter int               TICK_DIV   = 24000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ev_valid,
  output logic                                 ev_ready,
  input  logic                                 ev_note_on,
  input  logic [NOTE_W-1:0]                    ev_note,
  input  logic [FREQ_W-1:0]                    ev_freq,
  output logic [NUM_VOICES-1:0][FREQ_W-1:0]    frequencies,
  output logic [NUM_VOICES-1:0][VOL_W-1:0]     voice_volumes,
  output logic [NUM_VOICES-1:0]                voice_held
);
  import voice_pkg::*;

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  state_t state, state_nxt;
  logic scan_en, commit_en, accept;

  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [FREQ_W-1:0] ev_freq_q;

  logic [IDX_W-1:0] scan_idx, match_idx, free_idx, old_idx, tgt;
  logic             match_vld, free_vld, tgt_vld;

  logic [NUM_VOICES-1:0][NOTE_W-1:0] note;
  logic [NUM_VOICES-1:0]             held;
  logic [NUM_VOICES-1:0][IDX_W-1:0]  age;
  logic [NUM_VOICES-1:0][FREQ_W-1:0] freq;
  logic [NUM_VOICES-1:0][VOL_W-1:0]  vol;
  logic [NUM_VOICES-1:0]             load;

  logic [TICK_W-1:0] presc;
  logic              tick;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev_valid) state_nxt = SCAN;
      SCAN:    if (scan_idx == LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ev_ready  = (state == IDLE) && !reset;
    scan_en   = (state == SCAN);
    commit_en = (state == COMMIT);
  end

  assign accept = ev_valid && ev_ready;

  // Event latch and per-voice scan; match/age cannot change mid-scan, only vol can
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_freq_q <= '0;
      scan_idx  <= '0;
      match_vld <= 1'b0;
      free_vld  <= 1'b0;
      match_idx <= '0;
      free_idx  <= '0;
      old_idx   <= '0;
    end else if (accept) begin
      ev_on_q   <= ev_note_on;
      ev_note_q <= ev_note;
      ev_freq_q <= ev_freq;
      scan_idx  <= '0;
      match_vld <= 1'b0;
      free_vld  <= 1'b0;
    end else if (scan_en) begin
      scan_idx <= scan_idx + 1'b1;
      if (!match_vld && held[scan_idx] && note[scan_idx] == ev_note_q) begin
        match_vld <= 1'b1;
        match_idx <= scan_idx;
      end
      if (!free_vld && !held[scan_idx] && vol[scan_idx] == '0) begin
        free_vld <= 1'b1;
        free_idx <= scan_idx;
      end
      if (age[scan_idx] == LAST) old_idx <= scan_idx;
    end
  end

  always_comb begin
    tgt = old_idx;
    if (match_vld)     tgt = match_idx;
    else if (free_vld) tgt = free_idx;
    tgt_vld = ev_on_q || match_vld;
    load = '0;
    if (commit_en && ev_on_q) load[tgt] = 1'b1;
  end

  // Voice bookkeeping; a note-off only drops held so the release ramp starts
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        held[i] <= 1'b0;
        age[i]  <= IDX_W'(NUM_VOICES - 1 - i);
        freq[i] <= '0;
      end
    end else if (commit_en && tgt_vld) begin
      if (ev_on_q) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (age[i] < age[tgt]) age[i] <= age[i] + 1'b1;
        age[tgt]  <= '0;
        note[tgt] <= ev_note_q;
        held[tgt] <= 1'b1;
        freq[tgt] <= ev_freq_q;
      end else begin
        held[tgt] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_env
    voice_env #(
      .VOL_W    (VOL_W),
      .VOL_MAX  (VOL_MAX),
      .REL_STEP (REL_STEP)
    ) u_env (
      .clk   (clk),
      .reset (reset),
      .load  (load[g]),
      .held  (held[g]),
      .tick  (tick),
      .vol   (vol[g])
    );
  end

  assign tick = (presc == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frequencies   <= '0;
      voice_volumes <= '0;
      voice_held    <= '0;
    end else begin
      frequencies   <= freq;
      voice_volumes <= vol;
      voice_held    <= held;
    end
  end

endmodule
